// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: staircase sweep of the sine generator's phase increment.
// Walks delta from start to stop in step increments. Each value is held for
// dwell+1 clocks, with a start/busy/done handshake for the host.
// Optional feature macro: SINE_SWEEP_BIDIR_EN adds a down leg from stop back
// to start.
module sine_sweep_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_stop,
  input  logic [DW-1:0] cfg_step,
  input  logic [CW-1:0] cfg_dwell,
  output logic [DW-1:0] delta,
  output logic          busy,
  output logic          step_stb,
  output logic          done
);

`ifdef SINE_SWEEP_BIDIR_EN
  typedef enum logic [1:0] {IDLE, DWELL_UP, DWELL_DN, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, DWELL_UP, FINISH} state_t;
`endif

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] s_stop, s_step;
  logic [CW-1:0] s_dwell;
  logic          last;     // current delta is the final value of this leg
  logic          ld, adv_up;
  logic [DW:0]   up_sum;
  logic          up_last;
  logic [DW-1:0] up_val;

  // Up step: one extra bit catches wrap past the DW-bit range.
  assign up_sum  = {1'b0, delta} + {1'b0, s_step};
  assign up_last = up_sum[DW] | (up_sum[DW-1:0] >= s_stop);
  assign up_val  = up_last ? s_stop : up_sum[DW-1:0];

`ifdef SINE_SWEEP_BIDIR_EN
  logic [DW-1:0] s_start;
  logic          s_degen;  // start >= stop: no down leg
  logic          adv_dn;
  logic [DW:0]   dn_dif;
  logic          dn_last;
  logic [DW-1:0] dn_val;

  // Down step: the borrow bit flags underflow below zero.
  assign dn_dif  = {1'b0, delta} - {1'b0, s_step};
  assign dn_last = dn_dif[DW] | (dn_dif[DW-1:0] <= s_start);
  assign dn_val  = dn_last ? s_start : dn_dif[DW-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state decode plus the busy/done status and datapath strobes.
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    adv_up = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
`ifdef SINE_SWEEP_BIDIR_EN
    adv_dn = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
          nxt = DWELL_UP;
          ld  = 1'b1;
        end
      end
      DWELL_UP: begin
        busy = 1'b1;
        if (abort) nxt = IDLE;
        else if (cnt == '0) begin
          if (!last) adv_up = 1'b1;
`ifdef SINE_SWEEP_BIDIR_EN
          else if (!s_degen) begin
            nxt    = DWELL_DN;
            adv_dn = 1'b1;
          end
`endif
          else nxt = FINISH;
        end
      end
`ifdef SINE_SWEEP_BIDIR_EN
      DWELL_DN: begin
        busy = 1'b1;
        if (abort) nxt = IDLE;
        else if (cnt == '0) begin
          if (last) nxt = FINISH;
          else      adv_dn = 1'b1;
        end
      end
`endif
      FINISH: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: shadow config, delta, dwell counter, step strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      delta    <= '0;
      cnt      <= '0;
      last     <= 1'b0;
      step_stb <= 1'b0;
      s_stop   <= '0;
      s_step   <= '0;
      s_dwell  <= '0;
`ifdef SINE_SWEEP_BIDIR_EN
      s_start  <= '0;
      s_degen  <= 1'b0;
`endif
    end else begin
`ifdef SINE_SWEEP_BIDIR_EN
      step_stb <= ld | adv_up | adv_dn;
`else
      step_stb <= ld | adv_up;
`endif
      if (ld) begin
        s_stop  <= cfg_stop;
        s_step  <= (cfg_step == '0) ? DW'(1) : cfg_step;
        s_dwell <= cfg_dwell;
        delta   <= cfg_start;
        cnt     <= cfg_dwell;
        last    <= (cfg_start >= cfg_stop);
`ifdef SINE_SWEEP_BIDIR_EN
        s_start <= cfg_start;
        s_degen <= (cfg_start >= cfg_stop);
`endif
      end else if (adv_up) begin
        delta <= up_val;
        last  <= up_last;
        cnt   <= s_dwell;
`ifdef SINE_SWEEP_BIDIR_EN
      end else if (adv_dn) begin
        delta <= dn_val;
        last  <= dn_last;
        cnt   <= s_dwell;
`endif
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Scoreboard bench for sine_sweep_ctrl: every sweep pushes its expected
// per-cycle {delta,busy,step_stb,done} words. A monitor pops one word each
// cycle, sampling 1 time unit after the rising edge.
module tb_sine_sweep_ctrl;
  localparam int DW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [DW-1:0] cfg_start, cfg_stop, cfg_step;
  logic [CW-1:0] cfg_dwell;
  logic [DW-1:0] delta;
  logic          busy, step_stb, done;

  int checks = 0, failures = 0;
  int cur = 0;                // model of delta held between sweeps
  logic [31:0] sb[$];

  sine_sweep_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .delta(delta), .busy(busy),
    .step_stb(step_stb), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (delta,busy,stb,done packed)", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int d, input bit b, input bit s, input bit dn);
    logic [31:0] dv;
    dv = d;
    return {17'd0, dv[11:0], b, s, dn};
  endfunction

  // Monitor: one scoreboard word per cycle while expectations are pending.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) chk("seq", {17'd0, delta, busy, step_stb, done}, sb.pop_front());
  end

  // Reference staircase model; pushes at most lim words (lim<0: all).
  task automatic push_sweep(input int s, input int e, input int st, input int dw, input int lim);
    int vals[$];
    logic [31:0] tmp[$];
    int stp, v;
    stp = (st == 0) ? 1 : st;
    vals.push_back(s);
    if (s < e) begin
      v = s;
      while (v < e) begin
        v = v + stp;
        if (v >= e) v = e;
        vals.push_back(v);
      end
`ifdef SINE_SWEEP_BIDIR_EN
      while (v > s) begin
        v = v - stp;
        if (v <= s) v = s;
        vals.push_back(v);
      end
`endif
    end
    foreach (vals[i])
      for (int k = 0; k <= dw; k++) tmp.push_back(ent(vals[i], 1'b1, k == 0, 1'b0));
    v = vals[vals.size()-1];
    tmp.push_back(ent(v, 1'b0, 1'b0, 1'b1));
    tmp.push_back(ent(v, 1'b0, 1'b0, 1'b0));
    if (lim < 0) begin
      foreach (tmp[i]) sb.push_back(tmp[i]);
      cur = v;
    end else begin
      for (int i = 0; i < lim; i++) sb.push_back(tmp[i]);
    end
  endtask

  // Drives a one-cycle start at the next negedge; returns one negedge later.
  task automatic run(input int s, input int e, input int st, input int dw, input int lim);
    @(negedge clk);
    cfg_start = s[DW-1:0]; cfg_stop = e[DW-1:0];
    cfg_step  = st[DW-1:0]; cfg_dwell = dw[CW-1:0];
    start = 1'b1;
    push_sweep(s, e, st, dw, lim);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk(tag, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {17'd0, delta, busy, step_stb, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_out", {17'd0, delta, busy, step_stb, done}, 32'd0);

    run(1, 4, 1, 2, -1);        drain("basic");
    run(10, 20, 7, 0, -1);      drain("clamp");
    run(4090, 4095, 8, 1, -1);  drain("ovf");
    run(5, 7, 0, 0, -1);        drain("step0");
    run(9, 3, 1, 1, -1);        drain("degen");
`ifdef SINE_SWEEP_BIDIR_EN
    run(1, 4, 1, 0, -1);        drain("bidir");
`endif

    // start while busy plus cfg changes mid-sweep: sequence unchanged
    run(1, 4, 1, 2, -1);
    repeat (2) @(negedge clk);
    cfg_start = 12'd7; cfg_stop = 12'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("busy_start");

    // start and abort together in IDLE: nothing happens
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    cfg_start = 12'd3; cfg_stop = 12'd6; cfg_step = 12'd1; cfg_dwell = 16'd0;
    repeat (3) sb.push_back(ent(cur, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    drain("start_abort");

    // abort while delta=2: busy drops, delta holds, no done
    run(1, 4, 1, 2, 4);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    repeat (4) sb.push_back(ent(2, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    abort = 1'b0;
    cur = 2;
    drain("abort");

    // reset mid-sweep: outputs return to reset values on that edge
    run(1, 4, 1, 2, 5);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) sb.push_back(ent(0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cur = 0;
    drain("midrst");

    run(2, 5, 2, 1, -1);        drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
